// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide side unit.
//   mul_state_t : multiplier FSM encoding (IDLE, RUN, FIX)
//   MUL_ITER    : shift-add iterations per multiply
//   FUNCT_MULT / FUNCT_MULTU : funct codes the decoder uses to qualify start
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

    localparam int MUL_ITER = 32;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

endpackage

// File: rtl/mul_hilo_unit_hilo_regs.sv
// hilo_regs: architectural HI/LO flop pair.
//   clk, reset     : clock, async active-low reset (clears HI/LO)
//   commit         : load prod_hi/prod_lo (multiplier FIX edge)
//   prod_hi/lo     : product halves to commit
//   hi_we, lo_we   : mthi/mtlo strobes, already qualified by the caller
//   wd             : mthi/mtlo write data
//   hi, lo         : register outputs, straight from flops
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] prod_hi,
    input  logic [WIDTH-1:0] prod_lo,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // commit and the write strobes are never active together (commit happens
    // in FIX, writes only in IDLE); commit still wins for robustness.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= prod_hi;
            lo <= prod_lo;
        end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
        end
    end

endmodule

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: iterative WIDTH x WIDTH multiplier owning the HI/LO pair.
//   clk, reset        : clock, async active-low reset (aborts any operation)
//   start, signed_op  : launch mult (signed_op=1) / multu, sampled in IDLE only
//   a, b              : operands, sampled with start
//   hi_we, lo_we, wd  : mthi/mtlo writes, honoured in IDLE only
//   hi, lo            : architectural HI/LO
//   busy              : state is not IDLE (core stalls the PC on it)
//   done              : one-cycle pulse the cycle after HI/LO commit
// Sign handling is sign-magnitude: unsigned shift-add of |a| * |b|, negated at
// the end when the operand signs differ. Latency: 32 RUN edges + 1 FIX edge.
module mul_hilo_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;

    logic               idle;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod;

    assign idle = (state == IDLE);
    assign busy = !idle;

    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude, so no overflow case is needed.
    assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Accumulator top bit is always 0 after a shift, so the add cannot
    // overflow the WIDTH+1 bit accumulator.
    assign sum = acc + (mplier[0] ? {1'b0, mcand} : '0);

    assign prod_raw = {acc[WIDTH-1:0], mplier};
    assign prod     = neg ? (~prod_raw + 1'b1) : prod_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // {acc, mplier} <= {sum, mplier} >> 1
                    acc    <= {1'b0, sum[WIDTH:1]};
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk     (clk),
        .reset   (reset),
        .commit  (state == FIX),
        .prod_hi (prod[2*WIDTH-1:WIDTH]),
        .prod_lo (prod[WIDTH-1:0]),
        .hi_we   (hi_we & idle),
        .lo_we   (lo_we & idle),
        .wd      (wd),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: doc/mul_hilo_unit.md
# mul_hilo_unit

Iterative 32×32 multiplier with the architectural HI/LO register pair, sitting downstream of the main decoder in the single-cycle MIPS core. It consumes the decoder's special-register write strobe for `mult`/`multu` and produces a 64-bit product in HI/LO after a fixed multi-cycle latency. It asserts `busy` so the datapath can stall the PC while an operation is in flight. It also services `mthi`/`mtlo` writes and exposes HI/LO for `mfhi`/`mflo`.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `start` input 1: decoder `spregwrite` qualified by a mult-class funct. Sampled only in IDLE.
- `signed_op` input 1: 1 selects `mult` (two's complement), 0 selects `multu`. Sampled with `start`.
- `a`, `b` input WIDTH: rs and rt operands. Sampled with `start`.
- `hi_we`, `lo_we` input 1: `mthi`/`mtlo` write enables.
- `wd` input WIDTH: write data for `mthi`/`mtlo`.
- `hi`, `lo` output WIDTH: architectural registers, driven directly from flops.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse, registered, in the cycle after HI/LO commit.

## Operation
- States:
  - IDLE: on `start`, go to RUN.
  - RUN: after 32 iterations, go to FIX.
  - FIX: always go to IDLE.
- IDLE with `start=1`:
  - Latch `mcand = |a|` and `mplier = |b|`. Use magnitudes only when `signed_op=1`; otherwise take the raw operands.
  - Latch `neg = signed_op & (a[31]^b[31])`.
  - Clear the 33-bit accumulator. Load the iteration counter to 31.
- Magnitude rule: the magnitude of 0x80000000 is 0x80000000, treated as 32-bit unsigned. No overflow case exists.
- Each RUN cycle (shift-add on the 65-bit `{acc[32:0], mplier}`):
  - If `mplier[0]=1`, `acc += {1'b0, mcand}`.
  - Then shift `{acc, mplier}` right by one.
  - Decrement the counter. Leave RUN when the counter was 0.
- FIX:
  - `prod = {acc[31:0], mplier}`, negated in two's complement if `neg`.
  - Write `hi = prod[63:32]` and `lo = prod[31:0]`. Set `done=1` for the next cycle.
- `mthi`/`mtlo`:
  - Honoured only in IDLE. `hi_we` writes `wd` to HI; `lo_we` writes `wd` to LO. Both may be asserted in the same cycle.
  - `start` and a write in the same IDLE cycle: both are accepted. The write lands immediately, and the later FIX overwrites it.
- Ignored while `busy`: `start`, `hi_we` and `lo_we`. The core is required to stall on `busy`, so these cases indicate core misbehaviour.
- Reset asserted mid-operation: abort to IDLE. HI, LO, `done` and `busy` are all 0. No partial result is committed.

## Timing
- Reset values: `hi=0`, `lo=0`, `busy=0`, `done=0`, state IDLE, counter 0.
- The edge that samples `start` is E0.
- RUN iterations occur on edges E1 through E32.
- FIX commits HI/LO on edge E33.
- `busy` is high from the cycle after E0 through the cycle before E33's effect. It is low in the cycle where `done=1`.
- `done` is high for exactly the one cycle following E33. In that same cycle, `hi` and `lo` are valid and a new `start` may be sampled (back-to-back operation).
- Throughput: one multiply per 34 cycles.
- `hi` and `lo` never change except at a FIX edge, an IDLE write edge, or reset.

## Structure
- Shared package `mips_pkg`:
  - `mul_state_t` enum {IDLE, RUN, FIX}.
  - `MUL_ITER = 32`.
  - `FUNCT_MULT = 6'b011000` and `FUNCT_MULTU = 6'b011001`, for the decoder-side qualifier.
- One sub-module is natural: `hilo_regs`, the HI/LO flop pair with write-enable muxing between FIX commit and `mthi`/`mtlo`.
- The shift-add datapath and FSM stay in `mul_hilo_unit`.

## Test plan
- Unsigned 3 × 5:
  - Response: `busy` high for 33 cycles; `done` after E33.
  - Result: `hi=0x00000000`, `lo=0x0000000F`.
- Signed 0xFFFFFFFF × 0x00000001 (−1 × 1):
  - Result: `hi=0xFFFFFFFF`, `lo=0xFFFFFFFF`.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF:
  - Result: `hi=0xFFFFFFFE`, `lo=0x00000001`.
- Signed 0x80000000 × 0x80000000:
  - Result: `hi=0x40000000`, `lo=0x00000000`.
- Busy-time inputs ignored:
  - Stimulus: `start` at cycle 10 of an operation, plus `hi_we` with `wd=0xDEADBEEF` while busy.
  - Response: both are ignored; the original product is committed.
  - Follow-up: `mtlo 0x12345678` in IDLE gives `lo=0x12345678` on the next cycle.
- Reset mid-operation:
  - Stimulus: `reset` low at cycle 20 of RUN.
  - Response: `hi=lo=0` and `busy=done=0` immediately.
  - Follow-up: after release, a fresh 7 × 6 completes with `lo=0x2A`.
